edge_pack_writer: RTL and testbench
===================================

# edge_pack_writer

PCPI coprocessor directly downstream of the Sobel edge coprocessor. The CPU issues one custom instruction per pixel carrying the thresholded edge magnitude returned by the Sobel coprocessor. The block packs four consecutive 8-bit results into one 32-bit word and writes it to the output image region of data memory. It also supports an explicit flush and a status readback of words written.

## Interface
Parameters:
- OUT_BASE, 540672: word address of output pixel (0,0); sits after the two 262144-word input images at 16384.
- ROW_BITS, 9: row/col field width; image is 512x512.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- pcpi_valid  in  1  CPU instruction offered
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  push: pixel value
- pcpi_rs2  in  32  push: row in [17:9], col in [8:0]
- pcpi_wr  out  1  high only with pcpi_ready on STATUS
- pcpi_rd  out  32  STATUS result; 0 otherwise
- pcpi_wait  out  1  high while a decoded instruction is in progress
- pcpi_ready  out  1  one-cycle completion pulse
- mem_valid  out  1  write request, held until mem_ready
- mem_write  out  1  equals mem_valid
- mem_addr  out  32  byte address, (word address)<<2
- mem_wdata  out  32  packed pixels, lane n = col[1:0]==n
- mem_wstrb  out  4  byte-lane mask of valid bytes
- mem_ready  in  1  memory accepted write; sampled only while mem_valid

## Operation
- Decode: pcpi_valid && insn[6:0]==7'b0101011 && insn[31:25]==7'b0000010. The Sobel coprocessor uses funct7 0000001, so there is no overlap. insn[14:12] selects the op: 000 PUSH, 001 FLUSH, 010 STATUS. Other funct3 values complete as a no-op.
- Buffer state: buf_data[31:0], buf_mask[3:0], buf_widx[15:0], words_written[31:0].
- PCPI operands are latched at accept.
- Pixel index = row*512 + col. widx = index>>2. lane = col[1:0].
- States: IDLE, MERGE, WRITE, DONE.
- IDLE:
  - On decoded PUSH: if buf_mask!=0 and buf_widx!=widx, go to WRITE (evict) with push pending; else go to MERGE.
  - On decoded FLUSH: go to WRITE if buf_mask!=0, else DONE.
  - On decoded STATUS: go to DONE.
- MERGE:
  - buf_data[lane] = pixel; buf_mask[lane] = 1; buf_widx = widx.
  - A repeated lane overwrites its byte.
  - If the resulting mask is 4'hF, go to WRITE (no push pending); else go to DONE.
- WRITE:
  - mem_valid=1, mem_addr=(OUT_BASE+buf_widx)<<2, mem_wdata=buf_data, mem_wstrb=buf_mask.
  - On mem_ready: clear buf_mask and increment words_written (wraps at 2^32). Then go to MERGE if a push is pending, else DONE.
- DONE:
  - pcpi_ready=1 for one cycle.
  - STATUS: pcpi_wr=1, pcpi_rd=words_written.
  - Return to IDLE.
- Pixel value: rs1[7:0], subject to Configuration.

## Timing
- Reset values: all outputs 0; state IDLE; buf_mask 0; buf_data 0; buf_widx 0; words_written 0.
- Reset mid-WRITE drops mem_valid at once and discards buffered pixels.
- pcpi_wait is combinational: high when (state IDLE and insn decodes) or state is MERGE or WRITE; low in DONE and for undecoded instructions.
- Accept cycle is T0. Latencies to pcpi_ready:
  - PUSH, no write: pcpi_ready at T2.
  - PUSH completing a word: mem_valid from T2; pcpi_ready at the cycle after mem_ready (T3 minimum).
  - PUSH with eviction: WRITE from T1; MERGE the cycle after mem_ready; DONE the cycle after MERGE. If the merged word is full, a second WRITE follows before DONE.
  - FLUSH, empty buffer: pcpi_ready at T1, no memory traffic.
  - STATUS: pcpi_ready at T1.
- mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid is high. No new PCPI accept occurs until back in IDLE.
- A mem_ready seen while mem_valid is low is ignored.

## Configuration
- EDGE_PACK_SAT_EN:
  - Defined: pixel = (rs1 > 255 unsigned) ? 8'hFF : rs1[7:0].
  - Undefined: pixel = rs1[7:0] (truncation).

## Test plan
- Reset, then PUSH pixels 10,20,30,40 at row 1, cols 0..3 -> one write, mem_addr=(540672+128)<<2=0x0021_0200, wdata=0x281E140A, wstrb=4'hF; words_written=1.
- PUSH 0xC8 at (2,5), then PUSH at (2,9) -> eviction write wstrb=4'b0010, wdata[15:8]=0xC8, addr word 540672+257; the new pixel stays buffered with mask 4'b0010.
- FLUSH on empty buffer -> pcpi_ready at T1, mem_valid never asserted; FLUSH after one PUSH at lane 3 -> a single write with wstrb=4'b1000.
- PUSH rs1=300: with EDGE_PACK_SAT_EN stored byte 0xFF; without it, 0x2C.
- Hold mem_ready low 20 cycles during WRITE -> mem_valid and address/data stable, pcpi_wait high throughout; assert resetn low mid-wait -> all outputs 0 next edge, STATUS after reset returns 0 with pcpi_wr=1.
- Two PUSHes to the same lane (vals 5 then 7) then FLUSH -> written byte 0x07, words_written increments by 1.

Source files
------------

// File: rtl/edge_pack_writer_if.sv
// PCPI instruction port plus memory write port of the edge pack writer.
// master = CPU/memory side, slave = the coprocessor.
interface edge_pack_writer_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, mem_ready,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, mem_ready,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/edge_pack_writer.sv
// PCPI coprocessor packing four 8-bit edge pixels per 32-bit word; PUSH completes in 2 cycles plus
// any write time, writes hold until mem_ready. EDGE_PACK_SAT_EN saturates pixels above 255.
module edge_pack_writer #(
  parameter int OUT_BASE = 540672,
  parameter int ROW_BITS = 9
) (
  input  logic              clk,
  input  logic              resetn,
  edge_pack_writer_if.slave bus
);
  localparam int IDX_W = 2 * ROW_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MERGE, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_FLUSH, OP_STATUS, OP_NOP} op_t;

  state_t      r_state;
  state_t      w_next;
  op_t         r_op;
  op_t         w_op;
  logic [31:0] r_data;
  logic [3:0]  r_mask;
  logic [15:0] r_widx;
  logic [31:0] r_ww;
  logic [7:0]  r_pix;
  logic [1:0]  r_lane;
  logic [15:0] r_nwidx;
  logic        r_pend;

  logic             w_dec;
  logic             w_accept;
  logic             w_evict;
  logic [7:0]       w_pix;
  logic [IDX_W-1:0] w_index;
  logic [15:0]      w_widx;
  logic [3:0]       w_mmask;
  logic [31:0]      w_waddr;
  logic             w_unused;

  assign w_dec = bus.pcpi_valid && (bus.pcpi_insn[6:0] == 7'b0101011)
                 && (bus.pcpi_insn[31:25] == 7'b0000010);

  always_comb begin
    case (bus.pcpi_insn[14:12])
      3'b000:  w_op = OP_PUSH;
      3'b001:  w_op = OP_FLUSH;
      3'b010:  w_op = OP_STATUS;
      default: w_op = OP_NOP;
    endcase
  end

`ifdef EDGE_PACK_SAT_EN
  assign w_pix = (bus.pcpi_rs1 > 32'd255) ? 8'hFF : bus.pcpi_rs1[7:0];
`else
  assign w_pix = bus.pcpi_rs1[7:0];
`endif

  // {row,col} is already row*512+col; four pixels share one word
  assign w_index = bus.pcpi_rs2[IDX_W-1:0];
  assign w_widx  = 16'(w_index >> 2);
  assign w_evict = (r_mask != 4'b0000) && (r_widx != w_widx);
  assign w_mmask = r_mask | (4'b0001 << r_lane);
  assign w_waddr = 32'(OUT_BASE) + {16'b0, r_widx};

  assign w_unused = ^{bus.pcpi_rs1[31:8], bus.pcpi_rs2[31:IDX_W], bus.pcpi_insn[24:15],
                      bus.pcpi_insn[11:7], w_waddr[31:30]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'b0;
    bus.mem_valid  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = 32'b0;
    bus.mem_wdata  = 32'b0;
    bus.mem_wstrb  = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_dec) begin
          w_accept      = 1'b1;
          bus.pcpi_wait = resetn;
          case (w_op)
            OP_PUSH:  w_next = w_evict ? S_WRITE : S_MERGE;
            OP_FLUSH: w_next = (r_mask != 4'b0000) ? S_WRITE : S_DONE;
            default:  w_next = S_DONE;
          endcase
        end
      end
      S_MERGE: begin
        bus.pcpi_wait = 1'b1;
        w_next        = (w_mmask == 4'hF) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        bus.pcpi_wait = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = {w_waddr[29:0], 2'b00};
        bus.mem_wdata = r_data;
        bus.mem_wstrb = r_mask;
        if (bus.mem_ready) w_next = r_pend ? S_MERGE : S_DONE;
      end
      S_DONE: begin
        bus.pcpi_ready = 1'b1;
        if (r_op == OP_STATUS) begin
          bus.pcpi_wr = 1'b1;
          bus.pcpi_rd = r_ww;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op    <= OP_NOP;
      r_data  <= 32'b0;
      r_mask  <= 4'b0000;
      r_widx  <= 16'b0;
      r_ww    <= 32'b0;
      r_pix   <= 8'b0;
      r_lane  <= 2'b00;
      r_nwidx <= 16'b0;
      r_pend  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op;
        r_pix   <= w_pix;
        r_lane  <= w_index[1:0];
        r_nwidx <= w_widx;
        r_pend  <= (w_op == OP_PUSH) && w_evict;
      end
      if (r_state == S_MERGE) begin
        r_data[{r_lane, 3'b000} +: 8] <= r_pix;
        r_mask <= w_mmask;
        r_widx <= r_nwidx;
        r_pend <= 1'b0;
      end
      if (r_state == S_WRITE && bus.mem_ready) begin
        r_mask <= 4'b0000;
        r_ww   <= r_ww + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_edge_pack_writer.sv
// Bench for edge_pack_writer: directed scenarios then random PUSH/FLUSH/STATUS traffic
// against a word-level buffer model, with a per-cycle output monitor.
module tb_edge_pack_writer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  edge_pack_writer_if bus();

  edge_pack_writer #(.OUT_BASE(540672), .ROW_BITS(9)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int n_checks = 0;
  int n_err = 0;

  // model of the pixel buffer
  logic [7:0]  m_data [4];
  logic [3:0]  m_mask;
  int          m_widx;
  logic [31:0] m_ww;
  int          m_nw;
  wr_t         exp_q[$];

  // monitor state
  logic        force_low = 1'b0;
  logic        mon_active = 1'b0;
  wr_t         cur;
  int          mv_cycles = 0;
  int          n_acc = 0;
  logic [31:0] last_addr, last_data;
  logic [3:0]  last_strb;

  // results of the most recent instruction
  int          last_lat, last_k, last_nwr;
  logic        last_wr;
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix_of(input logic [31:0] v);
`ifdef EDGE_PACK_SAT_EN
    return (v > 32'd255) ? 8'hFF : v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
    m_mask = 4'b0000;
    m_widx = 0;
    m_ww = 32'd0;
    exp_q.delete();
  endtask

  task automatic m_emit();
    wr_t w;
    w.addr = 32'((540672 + m_widx) * 4);
    w.data = {m_data[3], m_data[2], m_data[1], m_data[0]};
    w.strb = m_mask;
    exp_q.push_back(w);
    m_mask = 4'b0000;
    m_ww++;
    m_nw++;
  endtask

  task automatic m_push(input logic [7:0] pix, input int row, input int col);
    int w, lane;
    w = (row * 512 + col) / 4;
    lane = col % 4;
    if (m_mask != 4'b0000 && m_widx != w) m_emit();
    m_data[lane] = pix;
    m_mask = m_mask | 4'(1 << lane);
    m_widx = w;
    if (m_mask == 4'hF) m_emit();
  endtask

  // mem_ready changes shortly after each rising edge; random unless held low
  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_ctrl", {27'b0, bus.mem_valid, bus.mem_write, bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_wait}, 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_strb", {28'b0, bus.mem_wstrb}, 32'd0);
      chk("rst_rd", bus.pcpi_rd, 32'd0);
      mon_active = 1'b0;
    end else begin
      chk("mem_write_eq_valid", bus.mem_write, bus.mem_valid);
      if (bus.pcpi_wr) chk("wr_needs_ready", bus.pcpi_ready, 1);
      else chk("rd_zero", bus.pcpi_rd, 32'd0);
      if (bus.pcpi_ready) chk("wait_low_in_done", bus.pcpi_wait, 0);
      if (bus.mem_valid) begin
        mv_cycles++;
        chk("wait_during_write", bus.pcpi_wait, 1);
        if (!mon_active) begin
          chk("write_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("wr_addr", bus.mem_addr, cur.addr);
            chk("wr_data", bus.mem_wdata, cur.data);
            chk("wr_strb", {28'b0, bus.mem_wstrb}, {28'b0, cur.strb});
          end
          cur.addr = bus.mem_addr;
          cur.data = bus.mem_wdata;
          cur.strb = bus.mem_wstrb;
          mon_active = 1'b1;
        end else begin
          chk("stable_addr", bus.mem_addr, cur.addr);
          chk("stable_data", bus.mem_wdata, cur.data);
          chk("stable_strb", {28'b0, bus.mem_wstrb}, {28'b0, cur.strb});
        end
        if (bus.mem_ready) begin
          mon_active = 1'b0;
          n_acc++;
          last_addr = bus.mem_addr;
          last_data = bus.mem_wdata;
          last_strb = bus.mem_wstrb;
        end
      end else begin
        chk("write_held", {31'b0, mon_active}, 32'd0);
        chk("idle_addr", bus.mem_addr, 32'd0);
        chk("idle_wdata", bus.mem_wdata, 32'd0);
        chk("idle_strb", {28'b0, bus.mem_wstrb}, 32'd0);
        mon_active = 1'b0;
      end
    end
  end

  task automatic do_insn(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         output int lat, output logic wr, output logic [31:0] rd,
                         output int k, output int nwr, output logic aborted);
    int mv0, acc0;
    logic got;
    lat = 0; wr = 1'b0; rd = 32'd0; aborted = 1'b0; got = 1'b0;
    @(negedge clk);
    bus.pcpi_insn  = {7'b0000010, 10'd0, f3, 5'd0, 7'b0101011};
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    bus.pcpi_valid = 1'b1;
    mv0 = mv_cycles;
    acc0 = n_acc;
    #1 chk("wait_on_decode", bus.pcpi_wait, 1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!resetn) begin
        aborted = 1'b1;
        break;
      end
      if (bus.pcpi_ready) begin
        got = 1'b1;
        wr = bus.pcpi_wr;
        rd = bus.pcpi_rd;
        break;
      end
    end
    if (!aborted) chk("insn_completes", {31'b0, got}, 1);
    bus.pcpi_valid = 1'b0;
    k = mv_cycles - mv0;
    nwr = n_acc - acc0;
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] rs1, input int row, input int col);
    int base, lat, k, nwr;
    logic wr, ab, exp_wr;
    logic [31:0] rd, exp_rd;
    m_nw = 0; base = 1; exp_wr = 1'b0; exp_rd = 32'd0;
    case (f3)
      3'd0: begin base = 2; m_push(pix_of(rs1), row, col); end
      3'd1: if (m_mask != 4'b0000) m_emit();
      3'd2: begin exp_wr = 1'b1; exp_rd = m_ww; end
      default: ;
    endcase
    do_insn(f3, rs1, 32'((row << 9) | col), lat, wr, rd, k, nwr, ab);
    last_lat = lat; last_k = k; last_nwr = nwr; last_wr = wr; last_rd = rd;
    if (!ab) begin
      chk("latency", lat, base + k);
      chk("write_count", nwr, m_nw);
      chk("pcpi_wr", wr, exp_wr);
      chk("pcpi_rd", rd, exp_rd);
    end
  endtask

  task automatic undecoded();
    @(negedge clk);
    bus.pcpi_insn  = {7'b0000001, 10'd0, 3'b000, 5'd0, 7'b0101011};
    bus.pcpi_rs1   = 32'd1;
    bus.pcpi_rs2   = 32'd0;
    bus.pcpi_valid = 1'b1;
    #1 chk("undecoded_wait", bus.pcpi_wait, 0);
    repeat (3) begin
      @(negedge clk);
      chk("undecoded_ready", bus.pcpi_ready, 0);
    end
    bus.pcpi_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ww0;
    int r;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn = 32'd0;
    bus.pcpi_rs1 = 32'd0;
    bus.pcpi_rs2 = 32'd0;
    m_reset();
    repeat (4) @(negedge clk);
    resetn = 1'b1;

    // four pixels of row 1 fill one word
    run(3'd0, 32'd10, 1, 0);
    run(3'd0, 32'd20, 1, 1);
    run(3'd0, 32'd30, 1, 2);
    run(3'd0, 32'd40, 1, 3);
    chk("t1_addr", last_addr, 32'h0021_0200);
    chk("t1_data", last_data, 32'h281E_140A);
    chk("t1_strb", {28'b0, last_strb}, 32'hF);
    run(3'd2, 32'd0, 0, 0);
    chk("t1_status", last_rd, 32'd1);

    // eviction on word change
    run(3'd0, 32'hC8, 2, 5);
    run(3'd0, 32'h33, 2, 9);
    chk("t2_evict_strb", {28'b0, last_strb}, 32'h2);
    chk("t2_evict_byte", {24'b0, last_data[15:8]}, 32'hC8);
    chk("t2_evict_addr", last_addr, 32'h0021_0404);
    chk("t2_model_mask", {28'b0, m_mask}, 32'h2);
    run(3'd1, 32'd0, 0, 0);
    chk("t2_flush_byte", {24'b0, last_data[15:8]}, 32'h33);
    chk("t2_flush_addr", last_addr, 32'h0021_0408);

    // flush of an empty buffer, then a single lane 3 flush
    run(3'd1, 32'd0, 0, 0);
    chk("t3_empty_lat", last_lat, 1);
    chk("t3_empty_writes", last_nwr, 0);
    run(3'd0, 32'd9, 5, 3);
    run(3'd1, 32'd0, 0, 0);
    chk("t3_lane3_strb", {28'b0, last_strb}, 32'h8);

    // out-of-range pixel value
    run(3'd0, 32'd300, 6, 0);
    run(3'd1, 32'd0, 0, 0);
`ifdef EDGE_PACK_SAT_EN
    chk("t4_pixel300", {24'b0, last_data[7:0]}, 32'hFF);
`else
    chk("t4_pixel300", {24'b0, last_data[7:0]}, 32'h2C);
`endif

    // same lane pushed twice
    run(3'd2, 32'd0, 0, 0);
    ww0 = last_rd;
    run(3'd0, 32'd5, 7, 1);
    run(3'd0, 32'd7, 7, 1);
    run(3'd1, 32'd0, 0, 0);
    chk("t5_overwrite", {24'b0, last_data[15:8]}, 32'h07);
    run(3'd2, 32'd0, 0, 0);
    chk("t5_count", last_rd, ww0 + 32'd1);

    // long memory stall
    force_low = 1'b1;
    run(3'd0, 32'd1, 3, 0);
    run(3'd0, 32'd2, 3, 1);
    run(3'd0, 32'd3, 3, 2);
    fork
      run(3'd0, 32'd4, 3, 3);
      begin
        repeat (22) @(posedge clk);
        force_low = 1'b0;
      end
    join
    chk("t6_stall_len", {31'b0, last_k >= 20}, 1);

    // reset in the middle of a stalled write
    force_low = 1'b1;
    run(3'd0, 32'd11, 4, 0);
    run(3'd0, 32'd12, 4, 1);
    run(3'd0, 32'd13, 4, 2);
    fork
      run(3'd0, 32'd14, 4, 3);
      begin
        repeat (6) @(posedge clk);
        #3 chk("t7_writing", bus.mem_valid, 1);
        resetn = 1'b0;
        #1;
        chk("t7_rst_valid", bus.mem_valid, 0);
        chk("t7_rst_wait", bus.pcpi_wait, 0);
        chk("t7_rst_addr", bus.mem_addr, 32'd0);
      end
    join
    repeat (2) @(negedge clk);
    m_reset();
    force_low = 1'b0;
    resetn = 1'b1;
    run(3'd2, 32'd0, 0, 0);
    chk("t7_status_rd", last_rd, 32'd0);
    chk("t7_status_wr", last_wr, 1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      run(3'd0, $urandom_range(0, 400), $urandom_range(0, 3), $urandom_range(0, 15));
      else if (r < 80) run(3'd1, 32'd0, 0, 0);
      else if (r < 90) run(3'd2, 32'd0, 0, 0);
      else if (r < 95) run(3'($urandom_range(3, 7)), 32'd0, 0, 0);
      else             undecoded();
    end
    run(3'd1, 32'd0, 0, 0);
    run(3'd2, 32'd0, 0, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
